// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - Y86 status codes returned with every completed access.
//   - FSM state encodings for the access sequencer (legacy-compatible
//     constants rather than an enum so existing decode logic keeps working).
package dmem_arbiter_pkg;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

endpackage

// File: rtl/dmem_grant_sel.sv
// Combinational winner select for the data-memory arbiter.
// Ports:
//   f_req      fetch request pending
//   m_req      memory-stage request pending
//   last_grant 1 = memory stage won the previous grant
//   grant_m    1 = memory stage wins, 0 = fetch wins (meaningful when a
//              request is pending)
// With last_grant tied low this is fixed priority, memory stage first.
// When both request, the side that did not win last time is chosen.
module dmem_grant_sel (
  input  logic f_req,
  input  logic m_req,
  input  logic last_grant,
  output logic grant_m
);

  always_comb begin
    grant_m = m_req & (~f_req | ~last_grant);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one RAM port between fetch (read-only) and
// the memory stage (read/write), sequences each access with a fixed-latency
// FSM and returns a Y86 status code with every completed access.
// Ports:
//   clk, rst                      clock, async active-high reset
//   f_req/f_addr/f_rdata/f_ack    fetch requester
//   m_req/m_we/m_addr/m_wdata/
//   m_rdata/m_ack                 memory-stage requester
//   stat                          status of the acked access (AOK/ADR)
//   ram_en/ram_we/ram_addr/
//   ram_wdata/ram_rdata           data-RAM macro interface
// Configuration macro: ARB_ROUND_ROBIN_EN -- when defined, simultaneous
// requests alternate between requesters; otherwise memory stage wins.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_ack,
  output logic [1:0]        stat,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W:0] ACC_BYTES = (ADDR_W+1)'(8);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [2:0]      LAT_INIT  = 3'(RD_LAT - 1);

  logic [1:0]        state;
  logic              owner_m;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        lat_cnt;
  logic              last_grant;

  logic              grant_m;
  logic              any_req;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_err;
  logic              take;
  logic              err_take;
  logic              capture;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] m_rdata_q;
  logic [1:0]        stat_q;

  dmem_grant_sel u_grant_sel (
    .f_req      (f_req),
    .m_req      (m_req),
    .last_grant (last_grant),
    .grant_m    (grant_m)
  );

  always_comb begin
    any_req  = f_req | m_req;
    sel_addr = grant_m ? m_addr : f_addr;
    sel_we   = grant_m & m_we;
    // One extra bit so addresses near the top of the space cannot wrap
    // back into the valid range.
    sel_err  = ({1'b0, sel_addr} + ACC_BYTES) > MEM_LIMIT;
    take     = (state == S_IDLE) & any_req;
    err_take = take & sel_err;
    capture  = ((state == S_ACCESS) && (RD_LAT == 1)) ||
               ((state == S_WAIT) && (lat_cnt == 3'd1));
    cap_data = we_q ? '0 : ram_rdata;
  end

  // Access sequencer and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      owner_m <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            owner_m <= grant_m;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= grant_m ? m_wdata : '0;
            state   <= sel_err ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (RD_LAT == 1) begin
            state <= S_DONE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == 3'd1) begin
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (take) begin
      last_grant <= grant_m;
    end
  end
`else
  always_comb begin
    last_grant = 1'b0;
  end
`endif

  // Per-requester return data and status; both hold outside DONE.
  // A bounds error is decided in IDLE, so its zero data and ADR status
  // are loaded there for the requester that is about to be acked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_rdata_q <= '0;
      m_rdata_q <= '0;
      stat_q    <= STAT_AOK;
    end else if (err_take) begin
      if (grant_m) m_rdata_q <= '0;
      else         f_rdata_q <= '0;
      stat_q <= STAT_ADR;
    end else if (capture) begin
      if (owner_m) m_rdata_q <= cap_data;
      else         f_rdata_q <= cap_data;
      stat_q <= STAT_AOK;
    end
  end

  always_comb begin
    f_ack     = (state == S_DONE) & ~owner_m;
    m_ack     = (state == S_DONE) & owner_m;
    f_rdata   = f_rdata_q;
    m_rdata   = m_rdata_q;
    stat      = stat_q;
    ram_en    = (state == S_ACCESS);
    ram_we    = (state == S_ACCESS) & we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (RD_LAT=2, MEM_BYTES=1024).
// A behavioural RAM answers the DUT's RAM port; a separate reference model
// predicts, per cycle, which ack/strobe must appear and with what data.
module tb_dmem_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MEMB = 1024;
  localparam int RDL  = 2;
  localparam int NCYC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_rdata;
  logic          f_ack;
  logic          m_req = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic [1:0]    stat;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_BYTES (MEMB),
    .RD_LAT    (RDL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_rdata   (f_rdata),
    .f_ack     (f_ack),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .stat      (stat),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [7:0] ram_mem [0:MEMB+7];
  logic [7:0] ref_mem [0:MEMB+7];

  bit          exp_fa [0:NCYC-1];
  bit          exp_ma [0:NCYC-1];
  bit          exp_en [0:NCYC-1];
  logic [63:0] exp_ad [0:NCYC-1];
  logic        exp_we [0:NCYC-1];
  logic [63:0] exp_wd [0:NCYC-1];
  logic [63:0] exp_rd [0:NCYC-1];
  logic [1:0]  exp_st [0:NCYC-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural RAM: data becomes visible the edge after the strobe cycle,
  // so it is stable RD_LAT=2 cycles after the strobe began.
  initial begin
    logic [63:0] rd;
    int unsigned a;
    forever begin
      @(posedge clk);
      if (!rst && ram_en) begin
        a  = int'(ram_addr[9:0]);
        rd = '0;
        for (int b = 0; b < 8; b++) begin
          if (ram_we) ram_mem[a+b] = ram_wdata[8*b +: 8];
          else        rd[8*b +: 8] = ram_mem[a+b];
        end
        ram_rdata <= rd;
      end
    end
  end

  // Reference model: one access at a time; a valid access strobes the RAM
  // in the cycle after it is taken and acks RD_LAT cycles after that
  // strobe; the arbiter is free again RD_LAT+2 cycles after taking it.
  // A bad address acks in the very cycle it is taken and frees after 2.
  initial begin
    int          free_at;
    bit          last_m;
    bit          pick_m;
    logic [63:0] a;
    logic [63:0] rd;
    bit          w;
    int unsigned base;
    free_at = 0;
    last_m  = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc < NCYC - 16) begin
        if (rst) begin
          for (int i = 0; i < 8; i++) begin
            exp_fa[cyc+i] = 1'b0;
            exp_ma[cyc+i] = 1'b0;
            exp_en[cyc+i] = 1'b0;
          end
          free_at = cyc + 1;
          last_m  = 1'b0;
        end else if (cyc >= free_at && (f_req || m_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick_m = m_req && !(f_req && last_m);
`else
          pick_m = m_req;
`endif
          last_m = pick_m;
          a = pick_m ? m_addr : f_addr;
          w = pick_m && m_we;
          if (a > 64'(MEMB - 8)) begin
            if (pick_m) exp_ma[cyc] = 1'b1; else exp_fa[cyc] = 1'b1;
            exp_rd[cyc] = '0;
            exp_st[cyc] = 2'd2;
            free_at = cyc + 2;
          end else begin
            base = int'(a[9:0]);
            rd = '0;
            for (int b = 0; b < 8; b++) begin
              if (w) ref_mem[base+b] = m_wdata[8*b +: 8];
              else   rd[8*b +: 8] = ref_mem[base+b];
            end
            exp_en[cyc] = 1'b1;
            exp_ad[cyc] = a;
            exp_we[cyc] = w;
            exp_wd[cyc] = m_wdata;
            if (pick_m) exp_ma[cyc+RDL] = 1'b1; else exp_fa[cyc+RDL] = 1'b1;
            exp_rd[cyc+RDL] = rd;
            exp_st[cyc+RDL] = 2'd0;
            free_at = cyc + RDL + 2;
          end
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < NCYC - 16) begin
        chk("f_ack", 64'(f_ack), 64'(exp_fa[cyc]));
        chk("m_ack", 64'(m_ack), 64'(exp_ma[cyc]));
        chk("ram_en", 64'(ram_en), 64'(exp_en[cyc]));
        chk("ack_exclusive", 64'(f_ack & m_ack), 64'd0);
        if (exp_en[cyc]) begin
          chk("ram_addr", ram_addr, exp_ad[cyc]);
          chk("ram_we", 64'(ram_we), 64'(exp_we[cyc]));
          if (exp_we[cyc]) chk("ram_wdata", ram_wdata, exp_wd[cyc]);
        end
        if (exp_fa[cyc]) begin
          chk("f_rdata", f_rdata, exp_rd[cyc]);
          chk("f_stat", 64'(stat), 64'(exp_st[cyc]));
        end
        if (exp_ma[cyc]) begin
          chk("m_rdata", m_rdata, exp_rd[cyc]);
          chk("m_stat", 64'(stat), 64'(exp_st[cyc]));
        end
      end
    end
  end

  task automatic m_access(input logic we, input logic [63:0] addr, input logic [63:0] data,
                          output logic [63:0] rd, output logic [1:0] st,
                          output int iss_c, output int ack_c);
    bit got;
    got = 1'b0;
    rd = '0; st = '0; ack_c = -1;
    @(negedge clk);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = data;
    iss_c = cyc;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (m_ack) begin
        got = 1'b1; rd = m_rdata; st = stat; ack_c = cyc;
      end
    end
    if (!got) chk("m_ack_timeout", 64'd0, 64'd1);
    m_req = 1'b0; m_we = 1'b0;
  endtask

  task automatic f_access(input logic [63:0] addr, output logic [63:0] rd,
                          output logic [1:0] st, output int ack_c);
    bit got;
    got = 1'b0;
    rd = '0; st = '0; ack_c = -1;
    @(negedge clk);
    f_req = 1'b1; f_addr = addr;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (f_ack) begin
        got = 1'b1; rd = f_rdata; st = stat; ack_c = cyc;
      end
    end
    if (!got) chk("f_ack_timeout", 64'd0, 64'd1);
    f_req = 1'b0;
  endtask

  initial begin
    logic [63:0] rd, frd;
    logic [1:0]  st, fst;
    int          ic, ac, fac, mac, prev_ac;
    bit          seen;

    for (int i = 0; i < MEMB + 8; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_f_ack", 64'(f_ack), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_stat", 64'(stat), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_m_rdata", m_rdata, 64'd0);
    chk("rst_ram_addr", ram_addr, 64'd0);
    rst = 1'b0;

    // 1: write then read back
    m_access(1'b1, 64'h10, 64'h1, rd, st, ic, ac);
    chk("t1_wr_stat", 64'(st), 64'd0);
    chk("t1_wr_latency", 64'(ac - ic), 64'd3);
    m_access(1'b0, 64'h10, 64'h0, rd, st, ic, ac);
    chk("t1_rd_data", rd, 64'h1);

    // 2: simultaneous requests, memory stage first
    fork
      m_access(1'b0, 64'h18, 64'h0, rd, st, ic, mac);
      f_access(64'h20, frd, fst, fac);
    join
    chk("t2_f_after_m", 64'(fac - mac), 64'd4);

    // 3: top valid quadword and first invalid one
    m_access(1'b0, 64'h3F8, 64'h0, rd, st, ic, ac);
    chk("t3_edge_stat", 64'(st), 64'd0);
    m_access(1'b1, 64'h3F9, 64'hDEAD_BEEF_CAFE_F00D, rd, st, ic, ac);
    chk("t3_err_stat", 64'(st), 64'd2);
    chk("t3_err_latency", 64'(ac - ic), 64'd1);
    for (int i = 'h3F9; i <= 'h400; i++) chk("t3_ram_untouched", 64'(ram_mem[i]), 64'd0);

    // 4: address that would wrap if checked at ADDR_W bits
    m_access(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, rd, st, ic, ac);
    chk("t4_wrap_stat", 64'(st), 64'd2);
    chk("t4_wrap_data", rd, 64'd0);

    // 5: reset during WAIT abandons the read
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h10;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ram_en) seen = 1'b1;
    end
    if (!seen) chk("t5_ram_en_timeout", 64'd0, 64'd1);
    @(negedge clk);
    #2 rst = 1'b1; m_req = 1'b0;
    #1;
    chk("t5_rst_m_ack", 64'(m_ack), 64'd0);
    chk("t5_rst_ram_en", 64'(ram_en), 64'd0);
    chk("t5_rst_ram_addr", ram_addr, 64'd0);
    chk("t5_rst_stat", 64'(stat), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_access(1'b0, 64'h10, 64'h0, rd, st, ic, ac);
    chk("t5_fresh_read", rd, 64'h1);
    chk("t5_fresh_stat", 64'(st), 64'd0);

    // 6: back-to-back overlapping writes, then a fetch of the result
    prev_ac = -1;
    for (int i = 0; i < 4; i++) begin
      m_access(1'b1, 64'(16 + i), 64'(i + 1), rd, st, ic, ac);
      if (i > 0) chk("t6_ack_spacing", 64'(ac - prev_ac), 64'd4);
      prev_ac = ac;
    end
    f_access(64'h10, frd, fst, fac);
    chk("t6_fetch_image", frd, 64'h0000_0000_0403_0201);
    chk("t6_fetch_stat", 64'(fst), 64'd0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
